// File: rtl/cmp_pipe_pkg.sv
// Shared types for the compare pipeline: the per-beat compare mode encoding.
package cmp_pipe_pkg;

    typedef enum logic [1:0] {
        CMP_NEQ = 2'd0,
        CMP_EQ  = 2'd1,
        CMP_GT  = 2'd2,
        CMP_LT  = 2'd3
    } cmp_mode_t;

endpackage

// File: rtl/cmp_pipe_v2_slice.sv
// One valid/ready register stage. Holds data and valid while downstream stalls;
// ready is combinational so a full chain pops and pushes in the same cycle.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/cmp_pipe_v2.sv
// Three-stage compare pipeline: S1 splits operands into B&C and A|B, S2 forms X3/X4,
// S3 registers the mode-selected flag, the X3^X4 mask and its popcount.
module cmp_pipe_v2
    import cmp_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [WIDTH-1:0]             c,
    input  logic [WIDTH-1:0]             d,
    input  logic [1:0]                   cmp_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_flag,
    output logic [WIDTH-1:0]             diff_mask,
    output logic [$clog2(WIDTH+1)-1:0]   diff_cnt
);

    localparam int CNTW = $clog2(WIDTH+1);
    localparam int S1W  = 2 + 3*WIDTH;
    localparam int S2W  = 2 + 2*WIDTH;
    localparam int S3W  = 1 + CNTW + WIDTH;

    logic [S1W-1:0] s1_d, s1_q;
    logic [S2W-1:0] s2_d, s2_q;
    logic [S3W-1:0] s3_d, s3_q;
    logic           s1_vld, s2_vld, s2_rdy, s3_rdy;

    assign s1_d = {cmp_mode, b & c, a | b, d};

    // S1 layout: {mode, X1, X2, D}; X3 folds D in here so S2 carries only X3/X4.
    assign s2_d = {s1_q[S1W-1 -: 2],
                   s1_q[3*WIDTH-1 -: WIDTH] ^ s1_q[WIDTH-1:0],
                   s1_q[2*WIDTH-1 -: WIDTH]};

    logic [WIDTH-1:0] x3, x4, mask_d;
    logic [CNTW-1:0]  cnt_d;
    logic             flag_d;
    cmp_mode_t        mode2;

    assign mode2 = cmp_mode_t'(s2_q[S2W-1 -: 2]);
    assign x3    = s2_q[2*WIDTH-1 -: WIDTH];
    assign x4    = s2_q[WIDTH-1:0];

    always_comb begin
        mask_d = x3 ^ x4;
        cnt_d  = '0;
        for (int i = 0; i < WIDTH; i++) cnt_d = cnt_d + CNTW'(mask_d[i]);
        flag_d = 1'b0;
        case (mode2)
            CMP_NEQ: flag_d = (x3 != x4);
            CMP_EQ:  flag_d = (x3 == x4);
            CMP_GT:  flag_d = (x3 > x4);
            CMP_LT:  flag_d = (x3 < x4);
            default: flag_d = 1'b0;
        endcase
    end

    assign s3_d = {flag_d, cnt_d, mask_d};

    pipe_slice #(.W(S1W)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(s1_d),
        .out_valid_o(s1_vld), .out_ready_i(s2_rdy), .out_data_o(s1_q)
    );

    pipe_slice #(.W(S2W)) u_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(s1_vld), .in_ready_o(s2_rdy), .in_data_i(s2_d),
        .out_valid_o(s2_vld), .out_ready_i(s3_rdy), .out_data_o(s2_q)
    );

    pipe_slice #(.W(S3W)) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(s2_vld), .in_ready_o(s3_rdy), .in_data_i(s3_d),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(s3_q)
    );

    assign out_flag  = s3_q[S3W-1];
    assign diff_cnt  = s3_q[WIDTH +: CNTW];
    assign diff_mask = s3_q[WIDTH-1:0];

endmodule
